jt51_i2s_tx: RTL and testbench
==============================

# jt51_i2s_tx

Serial audio transmitter that sits directly downstream of the JT51 accumulator. It captures the exact 16-bit stereo sample pair on each sample strobe and double-buffers it. It then shifts the pair out continuously in I2S format (32-bit frame, MSB first, one-bit data delay after the word-select edge) for an external DAC. It flags sample-rate mismatches between the synthesis side and the serial frame rate.

## Interface
- DIV, 2, clk cycles with cen=1 per sclk half-period; must be ≥1

- rst  in  1  synchronous, active-high reset
- clk  in  1  system clock, all logic on posedge
- cen  in  1  clock enable; no state changes when low
- sample  in  1  sample strobe, honoured only when cen=1 (driven from accumulator sample-complete pulse)
- left  in  16  signed left sample
- right  in  16  signed right sample
- sclk  out  1  serial bit clock, registered
- lrck  out  1  word select: 0 = left slot, 1 = right slot
- sdata  out  1  serial data, changes on sclk falling edge
- underrun  out  1  one-clk pulse: frame started with no new sample
- overrun  out  1  one-clk pulse: sample overwritten before transmission

## Operation
- Divider div_cnt counts 0..DIV-1 on cen cycles. On cen with div_cnt==DIV-1: div_cnt←0, sclk toggles.
- On every sclk 1→0 transition ("fall"):
  - bit_cnt (5 bits) increments mod 32.
  - lrck←new bit_cnt[4].
  - sdata←shreg[31]; shreg shifts left, filling with 0.
- Frame load on a fall where new bit_cnt==0:
  - sdata still takes the old shreg[31] (last right LSB).
  - shreg←{hold_l, hold_r} instead of the shift.
  - The next fall therefore emits left[15]: the I2S one-bit delay.
- Holding register, on cen && sample:
  - hold_l←left, hold_r←right, pend←1.
  - If pend was already 1, pulse overrun.
- At frame load:
  - pend=1: load hold, pend←0.
  - pend=0: reload the unchanged hold (repeat last pair) and pulse underrun.
- Simultaneous sample strobe and frame load in the same clk:
  - shreg loads the incoming left/right directly and hold updates.
  - pend ends at 0; no underrun, no overrun.
- Frame period is 64·DIV cen cycles. The integrator matches this to the sample period; any mismatch appears only as underrun/overrun pulses and never as a corrupted frame.

## Timing
- Reset values: sclk=0, lrck=1, sdata=0, underrun=0, overrun=0. Internally div_cnt=0, bit_cnt=31, shreg=0, hold=0, pend=0.
- Because bit_cnt=31, the first fall after reset is a frame load.
- Rst mid-frame returns all of the above on the next clk and aborts the frame.
- sclk, lrck and sdata all update in the same clk (registered, glitch-free); the DAC samples sdata on sclk rising.
- Latency from sample strobe to first data bit: at most one frame plus 2·DIV cen cycles.
- cen=0 freezes every register, including the divider. Pulses occur only on cen=1 clks and are exactly one clk wide.

## Structure
- Shared package/include holds FRAME_BITS=32 and SLOT_BITS=16, reused by a future receiver/testbench.
- Natural sub-module: jt51_i2s_div, the cen-qualified divider emitting sclk plus one-clk rise/fall strobes.
- The top holds the bit counter, shift register, holding buffer and flags.

## Test plan
- Reset, DIV=1, cen=1 constant -> sclk=0, lrck=1. sclk rises at clk1 and falls at clk2 with lrck→0, sdata=0; sclk period is 2 clks.
- sample with L=16'h8001, R=16'h7FFE before first load -> fall 1 sdata=0 (delay bit); falls 2..17 emit 1, fourteen 0s, 1; lrck→1 at fall 17; falls 18..33 emit 0, fourteen 1s, 0.
- No sample for 3 frames after one load -> underrun pulse at each frame load, and the same pair is repeated bit-exactly.
- Two strobes (L=1 then L=2) inside one frame -> one overrun pulse; the next frame carries L=2.
- Strobe coincident with frame-load clk (L=16'h1234) -> that frame carries 16'h1234; underrun=0, overrun=0.
- cen held low 10 clks mid-frame -> all outputs frozen. Rst asserted at bit_cnt=7 -> reset values next clk, then the first fall is a frame load.

Source files
------------

// File: rtl/jt51_i2s_pkg.sv
// Shared constants and types for the JT51 I2S serial audio path.
// Ports: none (package). FRAME_BITS/SLOT_BITS are meant to be reused by a
// future receiver or bench so frame geometry lives in exactly one place.
package jt51_i2s_pkg;

    localparam int FRAME_BITS = 32;
    localparam int SLOT_BITS  = 16;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    // One stereo pair; packed so {l, r} is also the MSB-first frame image.
    typedef struct packed {
        logic [SLOT_BITS-1:0] l;
        logic [SLOT_BITS-1:0] r;
    } pair_t;

    function automatic pair_t make_pair(input logic [SLOT_BITS-1:0] l,
                                        input logic [SLOT_BITS-1:0] r);
        pair_t p;
        p.l = l;
        p.r = r;
        return p;
    endfunction

endpackage

// File: rtl/jt51_i2s_div.sv
// cen-qualified bit-clock divider: registered sclk plus a one-clk fall strobe.
// Ports: clk_i/rst_i/cen_i in; sclk_o (registered), fall_o (combinational,
// high in the clk whose edge makes sclk go 1->0). Freezes entirely when cen_i=0.
module jt51_i2s_div #(
    parameter int DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cen_i,
    output logic sclk_o,
    output logic fall_o
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] div_cnt_q, div_cnt_d;
    logic         sclk_q, sclk_d;
    logic         tick;

    assign tick = cen_i && (div_cnt_q == W'(DIV - 1));

    always_comb begin
        div_cnt_d = div_cnt_q;
        sclk_d    = sclk_q;
        if (cen_i) begin
            if (tick) begin
                div_cnt_d = '0;
                sclk_d    = ~sclk_q;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;
    // The DAC samples on sclk rise, so the transmitter only acts on falls.
    assign fall_o = tick && sclk_q;

endmodule

// File: rtl/jt51_i2s_tx.sv
// I2S transmitter: double-buffers 16-bit stereo pairs and shifts 32-bit frames.
// Ports: clk_i/rst_i/cen_i, sample_i + left_i/right_i in; sclk_o/lrck_o/sdata_o
// (registered, updated together) and underrun_o/overrun_o (one-clk pulses) out.
module jt51_i2s_tx
    import jt51_i2s_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cen_i,
    input  logic                 sample_i,
    input  logic [SLOT_BITS-1:0] left_i,
    input  logic [SLOT_BITS-1:0] right_i,
    output logic                 sclk_o,
    output logic                 lrck_o,
    output logic                 sdata_o,
    output logic                 underrun_o,
    output logic                 overrun_o
);

    logic                  fall;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d, bit_nxt;
    logic                  lrck_q, lrck_d;
    logic                  sdata_q, sdata_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    pair_t                 hold_q, hold_d;
    logic                  pend_q, pend_d;
    logic                  strobe, load;
    logic                  underrun, overrun;

    jt51_i2s_div #(.DIV(DIV)) u_div (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .cen_i  (cen_i),
        .sclk_o (sclk_o),
        .fall_o (fall)
    );

    assign strobe  = cen_i && sample_i;
    assign bit_nxt = bit_cnt_q + 1'b1;
    assign load    = fall && (bit_nxt == '0);

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        lrck_d    = lrck_q;
        sdata_d   = sdata_q;
        shreg_d   = shreg_q;
        hold_d    = hold_q;
        pend_d    = pend_q;
        underrun  = 1'b0;
        overrun   = 1'b0;

        if (fall) begin
            bit_cnt_d = bit_nxt;
            lrck_d    = bit_nxt[CNT_W-1];
            // On a load fall this still emits the last right LSB; the new
            // left MSB appears one fall later (I2S one-bit delay).
            sdata_d   = shreg_q[FRAME_BITS-1];
            shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
        end

        if (load) begin
            // A strobe landing on the load clk bypasses the holding register
            // so the freshest pair is sent and no flag is raised.
            if (strobe) begin
                shreg_d = make_pair(left_i, right_i);
            end else begin
                shreg_d  = hold_q;
                underrun = !pend_q;
            end
            pend_d = 1'b0;
        end

        if (strobe) begin
            hold_d = make_pair(left_i, right_i);
            if (!load) begin
                pend_d  = 1'b1;
                overrun = pend_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt_q <= '1;    // first fall after reset becomes a frame load
            lrck_q    <= 1'b1;
            sdata_q   <= 1'b0;
            shreg_q   <= '0;
            hold_q    <= '0;
            pend_q    <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            lrck_q    <= lrck_d;
            sdata_q   <= sdata_d;
            shreg_q   <= shreg_d;
            hold_q    <= hold_d;
            pend_q    <= pend_d;
        end
    end

    assign lrck_o     = lrck_q;
    assign sdata_o    = sdata_q;
    // Flags are qualified by strobe/fall, both of which require cen_i, so
    // they are high only in the single clk that commits the event.
    assign underrun_o = underrun;
    assign overrun_o  = overrun;

endmodule

// File: tb/tb_jt51_i2s_tx.sv
module tb_jt51_i2s_tx;

    logic        clk = 1'b0;
    logic        rst, cen, sample;
    logic [15:0] left, right;
    logic        sclk, lrck, sdata, underrun, overrun;

    int n_chk  = 0;
    int n_pass = 0;

    jt51_i2s_tx #(.DIV(1)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cen_i      (cen),
        .sample_i   (sample),
        .left_i     (left),
        .right_i    (right),
        .sclk_o     (sclk),
        .lrck_o     (lrck),
        .sdata_o    (sdata),
        .underrun_o (underrun),
        .overrun_o  (overrun)
    );

    always #5 clk = ~clk;

    // One frame window: strobes issued at clk positions pos1/pos2 (0 = none)
    // inside the window, and what the window must show.
    typedef struct {
        int          pos1;
        logic [15:0] l1, r1;
        int          pos2;
        logic [15:0] l2, r2;
        logic [31:0] exp_word;
        int          exp_under;
        int          exp_over;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs the 64 clks after a load fall; clk 64 is the next load fall.
    task automatic run_frame(input vec_t v, output logic [31:0] word,
                             output int nu, output int no, output int lr_hi);
        word  = '0;
        nu    = 0;
        no    = 0;
        lr_hi = 0;
        for (int c = 1; c <= 64; c++) begin
            sample = (c == v.pos1) || (c == v.pos2);
            if (c == v.pos1) begin
                left = v.l1; right = v.r1;
            end else if (c == v.pos2) begin
                left = v.l2; right = v.r2;
            end
            @(negedge clk);
            nu += int'(underrun);
            no += int'(overrun);
            step();
            if (c % 2 == 0) word = {word[30:0], sdata};
            if (c < 64 && lrck) lr_hi++;
        end
        sample = 1'b0;
    endtask

    logic [31:0] word;
    int          nu, no, lr_hi;
    logic [2:0]  snap;

    initial begin
        vt[0] = '{0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 32'h8001_7FFE, 1, 0};
        vt[1] = '{0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 32'h8001_7FFE, 1, 0};
        vt[2] = '{0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 32'h8001_7FFE, 1, 0};
        vt[3] = '{10, 16'h0001, 16'hAAAA, 30, 16'h0002, 16'h5555, 32'h8001_7FFE, 0, 1};
        vt[4] = '{0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 32'h0002_5555, 1, 0};
        vt[5] = '{64, 16'h1234, 16'hABCD, 0, 16'h0, 16'h0, 32'h0002_5555, 0, 0};
        vt[6] = '{0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 32'h1234_ABCD, 1, 0};

        rst = 1'b1; cen = 1'b1; sample = 1'b0; left = '0; right = '0;
        repeat (3) step();
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_lrck", 32'(lrck), 32'd1);
        chk("rst_sdata", 32'(sdata), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // Strobe in the first clk out of reset, before the first load.
        rst = 1'b0; sample = 1'b1; left = 16'h8001; right = 16'h7FFE;
        @(negedge clk);
        chk("first_strobe_overrun", 32'(overrun), 32'd0);
        step();
        chk("clk1_sclk", 32'(sclk), 32'd1);
        chk("clk1_lrck", 32'(lrck), 32'd1);
        sample = 1'b0;
        @(negedge clk);
        chk("first_load_underrun", 32'(underrun), 32'd0);
        step();
        chk("clk2_sclk", 32'(sclk), 32'd0);
        chk("clk2_lrck", 32'(lrck), 32'd0);
        chk("clk2_delay_bit", 32'(sdata), 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_frame(vt[i], word, nu, no, lr_hi);
            chk($sformatf("frame%0d_word", i), word, vt[i].exp_word);
            chk($sformatf("frame%0d_underrun", i), 32'(nu), 32'(vt[i].exp_under));
            chk($sformatf("frame%0d_overrun", i), 32'(no), 32'(vt[i].exp_over));
            chk($sformatf("frame%0d_lrck_high", i), 32'(lr_hi), 32'd32);
        end

        // cen freeze mid-frame (frame carries 1234ABCD).
        repeat (9) step();
        snap = {sclk, lrck, sdata};
        chk("pre_freeze_sclk", 32'(sclk), 32'd1);
        cen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("freeze%0d", i), 32'({sclk, lrck, sdata}), 32'(snap));
        end
        cen = 1'b1;
        step();
        chk("resume_sclk", 32'(sclk), 32'd0);
        chk("resume_sdata", 32'(sdata), 32'd0);
        repeat (4) step();
        chk("bit7_sdata", 32'(sdata), 32'd1);

        // Reset with bit_cnt=7, on a clk where sclk would otherwise rise.
        rst = 1'b1;
        step();
        chk("midrst_sclk", 32'(sclk), 32'd0);
        chk("midrst_lrck", 32'(lrck), 32'd1);
        chk("midrst_sdata", 32'(sdata), 32'd0);
        rst = 1'b0;
        step();
        chk("postrst_rise", 32'(sclk), 32'd1);
        @(negedge clk);
        chk("postrst_load_underrun", 32'(underrun), 32'd1);
        step();
        chk("postrst_load_lrck", 32'(lrck), 32'd0);
        run_frame(vt[0], word, nu, no, lr_hi);
        vt[0].exp_word = 32'h0;
        chk("postrst_word", word, vt[0].exp_word);
        chk("postrst_underrun", 32'(nu), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
